// File: rtl/div32_iterative.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one trial subtraction per clock,
// quotient to LO and remainder to HI, with sign fixup in a final cycle.
module div32_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of 0x80000000 wraps back to itself, which is the intended unsigned reading.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_val(v) : v;
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] pr_r, sr_r, dmag_r, dividend_r;
  logic             sign_q_r, sign_r_r, dz_r;
  logic             busy_r, done_r, div_by_zero_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  logic [WIDTH:0]   rem_shift_s, trial_s;
  logic             qbit_s;
  logic [WIDTH-1:0] pr_next_s, q_fix_s, r_fix_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (count_r == CW'(WIDTH - 1)) state_s = FIX;
        else                           state_s = RUN;
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Trial subtraction; the shifted-in MSB makes the partial remainder WIDTH+1 bits wide
  always_comb begin
    rem_shift_s = {pr_r, sr_r[WIDTH-1]};
    trial_s     = rem_shift_s - {1'b0, dmag_r};
    qbit_s      = ~trial_s[WIDTH];
    if (qbit_s) pr_next_s = trial_s[WIDTH-1:0];
    else        pr_next_s = rem_shift_s[WIDTH-1:0];
  end

  // Final result selection, including divide-by-zero override
  always_comb begin
    q_fix_s = sr_r;
    r_fix_s = pr_r;
    if (dz_r) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = dividend_r;
    end else begin
      q_fix_s = sign_q_r ? neg_val(sr_r) : sr_r;
      r_fix_s = sign_r_r ? neg_val(pr_r) : pr_r;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r       <= '0;
      pr_r          <= '0;
      sr_r          <= '0;
      dmag_r        <= '0;
      dividend_r    <= '0;
      sign_q_r      <= 1'b0;
      sign_r_r      <= 1'b0;
      dz_r          <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      div_by_zero_r <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dividend_r    <= dividend;
            dmag_r        <= abs_val(divisor, is_signed);
            sr_r          <= abs_val(dividend, is_signed);
            pr_r          <= '0;
            sign_q_r      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_r      <= is_signed & dividend[WIDTH-1];
            dz_r          <= (divisor == '0);
            count_r       <= '0;
            busy_r        <= 1'b1;
            div_by_zero_r <= 1'b0;
          end
        end
        RUN: begin
          pr_r    <= pr_next_s;
          sr_r    <= {sr_r[WIDTH-2:0], qbit_s};
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          quotient_r    <= q_fix_s;
          remainder_r   <= r_fix_s;
          div_by_zero_r <= dz_r;
          done_r        <= 1'b1;
          busy_r        <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_div32_iterative.sv
// Directed, table-driven bench for div32_iterative: results, latency, handshake and reset.
module tb_div32_iterative;

  logic        clk, rst_n, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;

  div32_iterative #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present operands at a falling edge; returns just after the accepting rising edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts rising edges since acceptance (starting from c0) until done is seen.
  task automatic wait_done(input int c0, output int cyc);
    logic busy_ok;
    cyc = c0;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk("busy_during_op", {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic hold_ok;

    vecs[0]  = '{"u_100_7",       1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{"s_m7_2",        1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{"s_7_m2",        1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[3]  = '{"s_ovf",         1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[4]  = '{"u_max_1",       1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{"u_dz",          1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[6]  = '{"s_dz",          1'b1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[7]  = '{"s_m100_7",      1'b1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[8]  = '{"u_big_div",     1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, 1'b0};
    vecs[9]  = '{"u_small_big",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[10] = '{"s_dz_neg",      1'b1, 32'h87654321, 32'h00000000, 32'hFFFFFFFF, 32'h87654321, 1'b1};
    vecs[11] = '{"u_9_3",         1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy_rise"}, {31'b0, busy}, 32'd1);
      wait_done(0, cyc);
      chk({vecs[i].name, "_latency"}, cyc, 32'd33);
      chk({vecs[i].name, "_q"}, quotient, vecs[i].q);
      chk({vecs[i].name, "_r"}, remainder, vecs[i].r);
      chk({vecs[i].name, "_dz"}, {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
      chk({vecs[i].name, "_busy_low"}, {31'b0, busy}, 32'd0);
    end

    // Results hold and done stays low while idle
    hold_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || quotient !== 32'd3 || remainder !== 32'd0) hold_ok = 1'b0;
    end
    chk("hold_idle", {31'b0, hold_ok}, 32'd1);

    // start during RUN is ignored
    start_op(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, cyc);
    chk("ign_latency", cyc, 32'd33);
    chk("ign_q", quotient, 32'd14);
    chk("ign_r", remainder, 32'd2);

    // start in the done cycle is accepted
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dcs_done_fall", {31'b0, done}, 32'd0);
    chk("dcs_busy_rise", {31'b0, busy}, 32'd1);
    wait_done(0, cyc);
    chk("dcs_latency", cyc, 32'd33);
    chk("dcs_q", quotient, 32'd3);
    chk("dcs_r", remainder, 32'd0);

    // Asynchronous reset mid-operation discards the operation
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("arst_no_done", done_seen, 32'd0);

    start_op(1'b0, 32'd100, 32'd7);
    wait_done(0, cyc);
    chk("fresh_latency", cyc, 32'd33);
    chk("fresh_q", quotient, 32'd14);
    chk("fresh_r", remainder, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
